data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Responder end of the CPU data-SRAM port: a synchronous, byte-writable word memory. It accepts the access presented by EX (enable, byte write mask, address, write data) and returns read data one cycle later, aligned with the MEM stage's use of `data_sram_rdata`. After reset it zero-fills its array under a small state machine and raises a stall request until the fill completes.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 12: word-index bits; depth = 2^ADDR_WIDTH words, which is 16 KB at the default.
- `CLEAR_ON_RESET`, default 1: 1 = zero-fill the array after reset; 0 = go straight to READY (array contents undefined).

**Ports**
- `clk`, input, 1: clock; all logic updates on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `data_sram_en`, input, 1: access request this cycle.
- `data_sram_wen`, input, 4: byte write mask; bit i writes byte i, i.e. bits [8i+7:8i]. All zeros means a read.
- `data_sram_addr`, input, 32: byte address. The word index is `addr[ADDR_WIDTH+1:2]`; `addr[1:0]` is ignored.
- `data_sram_wdata`, input, 32: store data, already byte-lane aligned by EX.
- `data_sram_rdata`, output, 32: registered read data.
- `stallreq_mem`, output, 1: high while the clear sequence runs; drives the stall controller.
- `addr_err`, output, 1: one-cycle pulse, aligned with `data_sram_rdata`, flagging an out-of-range access.

## Operation

- **Range check:** an access is in range iff `addr[31:ADDR_WIDTH+2] == 0`.
- **FSM states:** CLEAR, READY.
  - **Reset:** `rst` moves the FSM to CLEAR when CLEAR_ON_RESET=1, otherwise to READY. It also zeroes the clear counter.
  - **CLEAR:** each cycle, write 0 to word `clr_idx`, then increment `clr_idx`. When `clr_idx == DEPTH-1` is written, go to READY the next cycle. `stallreq_mem` = 1 throughout CLEAR.
  - **READY:** serves requests. It stays in READY until `rst`.
- **Requests during CLEAR:** ignored, with no write. `data_sram_rdata` <= 0 and `addr_err` <= 0.
- **READY with `en`=1 and in range:**
  - **Write bytes:** for each set bit of `wen`, write the corresponding byte of `wdata` into the addressed word.
  - **Return data (write-first):** `data_sram_rdata` <= the merged word. Bytes come from `wdata` where `wen` is set and from the old contents elsewhere. A pure read (`wen`=0) returns the old word.
  - **Flag:** `addr_err` <= 0.
- **READY with `en`=1 and out of range:** no array write, `data_sram_rdata` <= 0, `addr_err` <= 1.
- **READY with `en`=0:** `data_sram_rdata` holds its previous value and `addr_err` <= 0. This holds rdata stable when EX is bubbled.
- **Back-to-back accesses to the same word:** the second access sees the first access's write. There is no hazard or bypass logic beyond the write-first merge.
- **Reset mid-clear or mid-traffic:** `clr_idx` restarts at 0 and the whole array is re-cleared. Any access in the reset cycle is discarded.

## Timing

- **Reset values:** `data_sram_rdata` = 0, `addr_err` = 0, `stallreq_mem` = 1 (CLEAR_ON_RESET=1) or 0 (CLEAR_ON_RESET=0).
- **`stallreq_mem` is registered:**
  - It rises in the cycle after the `rst` cycle.
  - It stays high for exactly DEPTH cycles.
  - It falls in the same cycle the FSM enters READY.
- **Read latency:** 1 cycle. A request sampled at edge N yields `data_sram_rdata` valid after edge N, held until the next enabled access.
- **Write latency:** the write is committed at the sampling edge and is visible to a read issued in the next cycle.
- **Throughput:** 1 access per cycle in READY, with no back-pressure except `stallreq_mem`.

## Test plan

- **Reset and clear** (ADDR_WIDTH=4): assert `rst` for 1 cycle, then release. Required: `stallreq_mem` = 1 for exactly 16 cycles, then 0. A read of every address 0x00–0x3C then returns 0x00000000.
- **Full write then read:** write `wen`=4'b1111, addr 0x10, wdata 0xDEADBEEF. Required: `rdata` = 0xDEADBEEF the next cycle. A read of 0x13 in the following cycle returns 0xDEADBEEF.
- **Byte-mask merge:**
  - Write 0x11223344 with `wen`=4'b0100 onto a word holding 0xDEADBEEF. Required: `rdata` = 0xDE22BEEF.
  - Then write 0x000000AA with `wen`=4'b0001. Required: `rdata` = 0xDE22BEAA.
- **Hold behaviour:** read 0x10 (0xDE22BEAA), then drive `en`=0 for 3 cycles with garbage addr/wdata. Required: `rdata` stays 0xDE22BEAA and the word is unchanged.
- **Out of range** (ADDR_WIDTH=4): read 0x40. Required: `rdata` = 0 and `addr_err` = 1 for one cycle. Write 0xFFFFFFFF to 0x80, then read 0x00. Required: 0x00000000 returned and `addr_err` pulses only on the 0x80 access.
- **Reset mid-clear:** assert `rst` at clear cycle 7. Required: `stallreq_mem` stays high 16 more cycles after the reset cycle. Requests issued during CLEAR return 0 and leave the array unchanged.

Source files
------------

// File: rtl/data_sram_responder_if.sv
// CPU data-SRAM port bundle: EX-side request plus registered MEM-side response.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_mem;
  logic        addr_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq_mem, addr_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq_mem, addr_err
  );
endinterface

// File: rtl/data_sram_responder.sv
// Byte-writable word SRAM responder with write-first read data and a
// post-reset zero-fill sequence that stalls the pipeline until done.
//
// state | meaning
// CLEAR | zero-filling word clr_idx each cycle, requests ignored, stall high
// READY | serving one access per cycle
module data_sram_responder #(
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  data_sram_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  acc_ok;
  logic                  clr_we;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic [31:0]           rdata_q;
  logic                  addr_err_q;
  logic                  stall_q;
  logic                  unused_addr_lsb;

  assign word_idx        = bus.data_sram_addr[ADDR_WIDTH+1:2];
  assign in_range        = (bus.data_sram_addr[31:ADDR_WIDTH+2] == '0);
  assign old_word        = mem[word_idx];
  assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_we     = 1'b0;
    acc_ok     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == {ADDR_WIDTH{1'b1}}) state_next = READY;
      end
      READY: acc_ok = bus.data_sram_en & in_range;
      default: state_next = RST_STATE;
    endcase
  end

  // Write-first merge: new bytes where the mask is set, old contents elsewhere.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (bus.data_sram_wen[i]) merged[8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         clr_idx <= '0;
    else if (clr_we) clr_idx <= clr_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)                             mem[clr_idx]  <= '0;
      else if (acc_ok && |bus.data_sram_wen)  mem[word_idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
      stall_q    <= CLEAR_ON_RESET;
    end else begin
      stall_q <= (state_next == CLEAR);
      if (state == CLEAR) begin
        rdata_q    <= '0;
        addr_err_q <= 1'b0;
      end else if (bus.data_sram_en) begin
        rdata_q    <= in_range ? merged : 32'h0;
        addr_err_q <= ~in_range;
      end else begin
        addr_err_q <= 1'b0;
      end
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign bus.addr_err        = addr_err_q;
  assign bus.stallreq_mem    = stall_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder at ADDR_WIDTH=4 (16 words).
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cnt;

  always #5 clk = ~clk;

  data_sram_responder_if bus ();

  data_sram_responder #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
  endtask

  initial begin
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check("rst_rdata", bus.data_sram_rdata, 32'h0);
    check("rst_err", {31'h0, bus.addr_err}, 32'h0);

    // stall length after reset
    cnt = 0;
    while (bus.stallreq_mem === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    check("stall_len", cnt, 32'd16);

    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'h0, 32'(a * 4), 32'h0);
      step();
      check("clear_read", bus.data_sram_rdata, 32'h0);
    end

    drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step();
    check("full_write", bus.data_sram_rdata, 32'hDEADBEEF);
    check("full_write_err", {31'h0, bus.addr_err}, 32'h0);
    drive(1'b1, 4'h0, 32'h13, 32'h0);
    step();
    check("read_0x13", bus.data_sram_rdata, 32'hDEADBEEF);

    drive(1'b1, 4'b0100, 32'h10, 32'h11223344);
    step();
    check("merge_b2", bus.data_sram_rdata, 32'hDE22BEEF);
    drive(1'b1, 4'b0001, 32'h10, 32'h000000AA);
    step();
    check("merge_b0", bus.data_sram_rdata, 32'hDE22BEAA);

    drive(1'b1, 4'h0, 32'h10, 32'h0);
    step();
    check("hold_read", bus.data_sram_rdata, 32'hDE22BEAA);
    drive(1'b0, 4'hF, 32'h10, 32'h5A5A5A5A);
    step();
    check("hold_1", bus.data_sram_rdata, 32'hDE22BEAA);
    drive(1'b0, 4'hF, 32'h14, 32'hA5A5A5A5);
    step();
    check("hold_2", bus.data_sram_rdata, 32'hDE22BEAA);
    check("hold_err", {31'h0, bus.addr_err}, 32'h0);
    drive(1'b0, 4'h3, 32'h84, 32'h01234567);
    step();
    check("hold_3", bus.data_sram_rdata, 32'hDE22BEAA);
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    step();
    check("hold_word", bus.data_sram_rdata, 32'hDE22BEAA);

    drive(1'b1, 4'h0, 32'h40, 32'h0);
    step();
    check("oor_rdata", bus.data_sram_rdata, 32'h0);
    check("oor_err", {31'h0, bus.addr_err}, 32'h1);
    drive(1'b1, 4'hF, 32'h80, 32'hFFFFFFFF);
    step();
    check("oor_wr_rdata", bus.data_sram_rdata, 32'h0);
    check("oor_wr_err", {31'h0, bus.addr_err}, 32'h1);
    drive(1'b1, 4'h0, 32'h00, 32'h0);
    step();
    check("oor_alias", bus.data_sram_rdata, 32'h0);
    check("oor_err_clr", {31'h0, bus.addr_err}, 32'h0);
    drive(1'b0, 4'h0, 32'h40, 32'h0);
    step();
    check("idle_err", {31'h0, bus.addr_err}, 32'h0);

    drive(1'b1, 4'hF, 32'h20, 32'h12345678);
    step();
    drive(1'b1, 4'h0, 32'h20, 32'h0);
    step();
    check("b2b_read", bus.data_sram_rdata, 32'h12345678);
    drive(1'b1, 4'b1000, 32'h20, 32'hAB000000);
    step();
    check("b2b_merge", bus.data_sram_rdata, 32'hAB345678);
    drive(1'b1, 4'h0, 32'h3C, 32'h0);
    step();
    check("last_word", bus.data_sram_rdata, 32'h0);

    // reset, then reset again at clear cycle 7 with traffic throughout
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("stall_pre", {31'h0, bus.stallreq_mem}, 32'h1);
      step();
    end
    rst = 1'b1;
    drive(1'b1, 4'hF, 32'h3C, 32'h55555555);
    step();
    rst = 1'b0;
    drive(1'b1, 4'hF, 32'h00, 32'hCAFEF00D);
    cnt = 0;
    while (bus.stallreq_mem === 1'b1 && cnt < 40) begin
      cnt++;
      check("clr_rdata", bus.data_sram_rdata, 32'h0);
      check("clr_err", {31'h0, bus.addr_err}, 32'h0);
      step();
    end
    check("stall_len2", cnt, 32'd16);
    check("clr_rdata_end", bus.data_sram_rdata, 32'h0);

    drive(1'b1, 4'h0, 32'h00, 32'h0);
    step();
    check("reclr_w0", bus.data_sram_rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    step();
    check("reclr_w4", bus.data_sram_rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h20, 32'h0);
    step();
    check("reclr_w8", bus.data_sram_rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h3C, 32'h0);
    step();
    check("reclr_w15", bus.data_sram_rdata, 32'h0);
    check("stall_ready", {31'h0, bus.stallreq_mem}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
